// File: rtl/result_if.sv
// Product handshake bundle between the datapath output shift register
// (master) and the result writer (slave).
interface result_if #(
    parameter int DATA_W = 32
);
    logic              prod_valid;
    logic [DATA_W-1:0] prod_data;
    logic              prod_ready;

    // Datapath side: offers products, watches ready.
    modport master (
        output prod_valid,
        output prod_data,
        input  prod_ready
    );

    // Writer side: consumes products, advertises ready.
    modport slave (
        input  prod_valid,
        input  prod_data,
        output prod_ready
    );
endinterface

// File: rtl/result_writer.sv
// result_writer: collects DEPTH products from the approximate-multiplier
// datapath into an in-order result memory, flags done once the run is full
// and offers a registered (1-cycle) read port for the host.
// Optional feature: define RESULT_CHECKSUM_EN to compute a running XOR of
// all accepted products on the checksum port; otherwise checksum is tied 0.
module result_writer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,       // asynchronous, active-low
    input  logic              start,
    result_if.slave           prod,
    output logic [ADDR_W:0]   wr_count,
    output logic              done,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [ADDR_W:0]   wr_count_q;
    logic [ADDR_W:0]   wr_count_d;
    logic              ready_q;
    logic              done_q;
    logic              mem_we;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rd_data_p1;

    // State, write pointer, counter and the state-decoded status flags.
    // ready/done are registered from the next state so they never see prod_valid
    // combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_count_q <= wr_count_d;
            ready_q    <= (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
        end
    end

    // Next-state logic; start always takes priority over a coincident transfer,
    // including the one that would have completed the run.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    wr_addr_d  = '0;
                    wr_count_d = '0;
                end
            end
            S_RUN: begin
                if (start) begin
                    wr_addr_d  = '0;
                    wr_count_d = '0;
                end else if (prod.prod_valid) begin
                    mem_we     = 1'b1;
                    wr_addr_d  = wr_addr_q + 1'b1;
                    wr_count_d = wr_count_q + 1'b1;
                    if (wr_count_d == DEPTH_CNT) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d    = S_RUN;
                    wr_addr_d  = '0;
                    wr_count_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wr_addr_d  = '0;
                wr_count_d = '0;
            end
        endcase
    end

    // Result memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= prod.prod_data;
        end
    end

    // --- read stage p1: registered readback, old data on same-cycle write ---
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_p1 <= '0;
        end else begin
            rd_data_p1 <= mem[rd_addr];
        end
    end

`ifdef RESULT_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    function automatic logic [DATA_W-1:0] fold_xor(
        input logic [DATA_W-1:0] acc,
        input logic [DATA_W-1:0] word
    );
        return acc ^ word;
    endfunction

    // Running XOR of accepted products; cleared by start, frozen outside RUN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else if (start) begin
            checksum_q <= '0;
        end else if (mem_we) begin
            checksum_q <= fold_xor(checksum_q, prod.prod_data);
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign prod.prod_ready = ready_q;
    assign done            = done_q;
    assign wr_count        = wr_count_q;
    assign rd_data         = rd_data_p1;

endmodule

// File: tb/tb_result_writer.sv
// Directed bench for result_writer: reset, full and gapped runs,
// backpressure outside RUN, restart cases, read-before-write and checksum.
module tb_result_writer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   wr_count;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] checksum;

    int n_vec;
    int n_err;

    result_if #(.DATA_W(DATA_W)) prod_if ();

    result_writer #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .prod    (prod_if),
        .wr_count(wr_count),
        .done    (done),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] word);
        prod_if.prod_valid = 1'b1;
        prod_if.prod_data  = word;
        tick();
        prod_if.prod_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
        rd_addr = ADDR_W'(addr);
        tick();
        check(tag, rd_data, exp);
    endtask

    int gaps [8] = '{0, 2, 1, 0, 3, 1, 2, 0};
    logic [31:0] exp_chk;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b0;
        start = 1'b0;
        rd_addr = '0;
        prod_if.prod_valid = 1'b0;
        prod_if.prod_data  = '0;

        // Reset values
        #1;
        check("rst_ready", 32'(prod_if.prod_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_checksum", checksum, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Backpressure in IDLE
        prod_if.prod_valid = 1'b1;
        prod_if.prod_data  = 32'hDEAD_BEEF;
        repeat (3) tick();
        prod_if.prod_valid = 1'b0;
        check("idle_bp_ready", 32'(prod_if.prod_ready), 32'd0);
        check("idle_bp_count", 32'(wr_count), 32'd0);

        // Full back-to-back run of words 1..8
        pulse_start();
        check("run_ready", 32'(prod_if.prod_ready), 32'd1);
        check("run_count0", 32'(wr_count), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            prod_if.prod_valid = 1'b1;
            prod_if.prod_data  = 32'(i);
            tick();
            check($sformatf("full_count%0d", i), 32'(wr_count), 32'(i));
        end
        prod_if.prod_valid = 1'b0;
        check("full_done", 32'(done), 32'd1);
        check("full_ready", 32'(prod_if.prod_ready), 32'd0);
`ifdef RESULT_CHECKSUM_EN
        exp_chk = 32'd8;
`else
        exp_chk = 32'd0;
`endif
        check("full_checksum", checksum, exp_chk);

        // Backpressure in DONE
        prod_if.prod_valid = 1'b1;
        prod_if.prod_data  = 32'hDEAD_BEEF;
        repeat (3) tick();
        prod_if.prod_valid = 1'b0;
        check("done_bp_count", 32'(wr_count), 32'd8);
        check("done_bp_done", 32'(done), 32'd1);
        check("done_bp_checksum", checksum, exp_chk);
        for (int a = 0; a < 8; a++) begin
            read_check($sformatf("full_rd%0d", a), a, 32'(a + 1));
        end

        // Gapped run of 0x101..0x108; first write also checks read-before-write
        pulse_start();
        check("gap_done_clr", 32'(done), 32'd0);
        check("gap_checksum_clr", checksum, 32'd0);
        rd_addr = '0;
        for (int i = 0; i < 8; i++) begin
            repeat (gaps[i]) tick();
            push(32'h100 + 32'(i + 1));
            if (i == 0) check("rbw_old_data", rd_data, 32'd1);
            check($sformatf("gap_count%0d", i + 1), 32'(wr_count), 32'(i + 1));
        end
        check("gap_done", 32'(done), 32'd1);
        for (int a = 0; a < 8; a++) begin
            read_check($sformatf("gap_rd%0d", a), a, 32'h100 + 32'(a + 1));
        end

        // Restart after 3 transfers
        pulse_start();
        push(32'hA1);
        push(32'hA2);
        push(32'hA3);
        check("rs_count3", 32'(wr_count), 32'd3);
        pulse_start();
        check("rs_count0", 32'(wr_count), 32'd0);
        check("rs_ready", 32'(prod_if.prod_ready), 32'd1);
        push(32'hB0);
        push(32'hB1);
        // start coincident with a transfer: 0xCC must be dropped
        start = 1'b1;
        prod_if.prod_valid = 1'b1;
        prod_if.prod_data  = 32'hCC;
        tick();
        start = 1'b0;
        prod_if.prod_valid = 1'b0;
        check("rs_coinc_count", 32'(wr_count), 32'd0);
        read_check("rs_rd0", 0, 32'hB0);
        read_check("rs_rd1", 1, 32'hB1);
        read_check("rs_rd2_dropped", 2, 32'hA3);

        // start coincident with the final transfer: start wins
        for (int i = 0; i < 7; i++) push(32'h200 + 32'(i));
        check("last_count7", 32'(wr_count), 32'd7);
        start = 1'b1;
        prod_if.prod_valid = 1'b1;
        prod_if.prod_data  = 32'h2FF;
        tick();
        start = 1'b0;
        prod_if.prod_valid = 1'b0;
        check("last_count0", 32'(wr_count), 32'd0);
        check("last_done", 32'(done), 32'd0);
        check("last_ready", 32'(prod_if.prod_ready), 32'd1);
        read_check("last_rd7_dropped", 7, 32'h108);

        // Checksum of 0x0F, 0xF0, 0xFF
        push(32'h0F);
`ifdef RESULT_CHECKSUM_EN
        check("chk_first", checksum, 32'h0F);
`else
        check("chk_first", checksum, 32'h0);
`endif
        push(32'hF0);
        push(32'hFF);
        check("chk_final", checksum, 32'h0);
        check("chk_count", 32'(wr_count), 32'd3);

        // Asynchronous reset mid-run, observed before the next edge
        #2;
        rst = 1'b0;
        #1;
        check("arst_ready", 32'(prod_if.prod_ready), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_count", 32'(wr_count), 32'd0);
        check("arst_checksum", checksum, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(prod_if.prod_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
